// File: rtl/spi_master_arbiter.sv
// Mode-0 SPI master shared by NUM_REQ requesters using round-robin arbitration.
// Define SPI_LSB_FIRST_EN to shift bytes LSB first; the default build shifts MSB first.

module spi_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] tx_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx_data,
  output logic                 SCLK,
  output logic                 CS,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE, GAP} state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   divCnt_q;
  logic [2:0]         bitCnt_q;
  logic [7:0]         txShift_q;
  logic [7:0]         rxShift_q;
  logic [7:0]         rxData_q;
  logic [IDX_W-1:0]   grantIdx_q;
  logic [IDX_W-1:0]   lastWinner_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;
  logic               done_q;
  logic               sclk_q;
  logic               cs_q;
  logic               mosi_q;

  logic               divDone;
  logic               winValid_d;
  logic [IDX_W-1:0]   winner_d;
  logic [IDX_W-1:0]   cand;
  logic [7:0]         txByte_d;
  logic [7:0]         txShifted_d;
  logic [7:0]         rxShifted_d;
  logic               firstBit_d;
  logic               nextBit_d;

  assign divDone = (divCnt_q == DIV_LAST);

  // Search starts just after the last winner so a held request cannot starve the others.
  always_comb begin
    winValid_d = 1'b0;
    winner_d   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(lastWinner_q) + k) % NUM_REQ);
      if (!winValid_d && req[cand]) begin
        winValid_d = 1'b1;
        winner_d   = cand;
      end
    end
  end

  always_comb begin
    txByte_d = tx_data[7:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_d == IDX_W'(i)) begin
        txByte_d = tx_data[8*i +: 8];
      end
    end
  end

`ifdef SPI_LSB_FIRST_EN
  assign firstBit_d  = txByte_d[0];
  assign txShifted_d = {1'b0, txShift_q[7:1]};
  assign nextBit_d   = txShift_q[1];
  assign rxShifted_d = {MISO, rxShift_q[7:1]};
`else
  assign firstBit_d  = txByte_d[7];
  assign txShifted_d = {txShift_q[6:0], 1'b0};
  assign nextBit_d   = txShift_q[6];
  assign rxShifted_d = {rxShift_q[6:0], MISO};
`endif

  // MISO is captured on the same edge that raises SCLK; MOSI moves on the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      divCnt_q     <= '0;
      bitCnt_q     <= '0;
      txShift_q    <= '0;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      grantIdx_q   <= '0;
      lastWinner_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      divCnt_q <= divDone ? '0 : divCnt_q + DIV_W'(1);
      case (state_q)
        IDLE: begin
          divCnt_q <= '0;
          if (winValid_d) begin
            grantIdx_q <= winner_d;
            gnt_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_d;
            txShift_q  <= txByte_d;
            mosi_q     <= firstBit_d;
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            bitCnt_q   <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (divDone) begin
            sclk_q    <= 1'b1;
            rxShift_q <= rxShifted_d;
            state_q   <= HIGH;
          end
        end
        HIGH: begin
          if (divDone) begin
            sclk_q  <= 1'b0;
            state_q <= LOW;
            if (bitCnt_q != 3'd7) begin
              txShift_q <= txShifted_d;
              mosi_q    <= nextBit_d;
            end
          end
        end
        LOW: begin
          if (divDone) begin
            if (bitCnt_q == 3'd7) begin
              cs_q         <= 1'b1;
              done_q       <= 1'b1;
              rxData_q     <= rxShift_q;
              lastWinner_q <= grantIdx_q;
              state_q      <= DONE;
            end else begin
              bitCnt_q  <= bitCnt_q + 3'd1;
              sclk_q    <= 1'b1;
              rxShift_q <= rxShifted_d;
              state_q   <= HIGH;
            end
          end
        end
        DONE: begin
          divCnt_q <= '0;
          gnt_q    <= '0;
          state_q  <= GAP;
        end
        GAP: begin
          if (divDone) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rxData_q;
  assign SCLK    = sclk_q;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: a transfer-level model checked every cycle
// plus directed transfers with hand-computed results; honours SPI_LSB_FIRST_EN.

module tb_spi_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 400;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] tx_data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 done;
  logic [7:0]           rx_data;
  logic                 SCLK;
  logic                 CS;
  logic                 MOSI;
  logic                 MISO;
  logic                 misoTied;
  logic                 misoLevel;

  logic [NUM_REQ-1:0]   req1;
  logic [8*NUM_REQ-1:0] txData1;
  logic [NUM_REQ-1:0]   gnt1;
  logic                 busy1;
  logic                 done1;
  logic [7:0]           rxData1;
  logic                 sclk1;
  logic                 cs1;
  logic                 mosi1;

  assign MISO = misoTied ? misoLevel : MOSI;

  spi_master_arbiter #(.NUM_REQ(NUM_REQ), .CLK_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .gnt(gnt), .busy(busy),
    .done(done), .rx_data(rx_data), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master_arbiter #(.NUM_REQ(NUM_REQ), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .tx_data(txData1), .gnt(gnt1), .busy(busy1),
    .done(done1), .rx_data(rxData1), .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(mosi1)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [7:0] sentOrder(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
    sentOrder = {<<{v}};
`else
    sentOrder = v;
`endif
  endfunction

  // Transfer-level model: everything follows from the offset since the arbitration edge.
  int         cyc = 0;
  bit         mActive = 1'b0;
  int         mStart = 0;
  int         mWin = 0;
  int         mLast = NUM_REQ - 1;
  logic [7:0] mTx = 8'h00;
  logic [7:0] mIn = 8'h00;
  logic [7:0] mRx = 8'h00;
  int         o, idx;

  logic [NUM_REQ-1:0] eGnt;
  logic               eBusy, eDone, eCs, eSclk, eMosi, eMosiValid;
  logic [7:0]         eRx;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mActive = 1'b0;
        mLast   = NUM_REQ - 1;
        mRx     = 8'h00;
      end else if (!mActive) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (mLast + k) % NUM_REQ;
          if (!mActive && ((req >> c) & 1) != 0) begin
            mActive = 1'b1;
            mWin    = c;
            mStart  = cyc;
            mTx     = 8'(tx_data >> (8 * c));
            mIn     = 8'h00;
          end
        end
      end else if (cyc - mStart == 18 * DIV + 1) begin
        mActive = 1'b0;
      end

      eGnt = '0; eBusy = 1'b0; eDone = 1'b0; eCs = 1'b1; eSclk = 1'b0;
      eMosi = 1'b0; eMosiValid = 1'b0;
      if (mActive) begin
        o = cyc - mStart;
        eBusy = 1'b1;
        if (o < 17 * DIV && o % DIV == 0 && (o / DIV) % 2 == 1) begin
          mIn = mIn | (8'(MISO) << (o / (2 * DIV)));
        end
        if (o == 17 * DIV) begin
`ifdef SPI_LSB_FIRST_EN
          mRx = mIn;
`else
          mRx = {<<{mIn}};
`endif
          mLast = mWin;
        end
        if (o <= 17 * DIV) eGnt = NUM_REQ'(1) << mWin;
        if (o < 17 * DIV) begin
          eCs  = 1'b0;
          eSclk = ((o / DIV) % 2) == 1;
          idx  = (o / DIV) / 2;
          if (idx > 7) idx = 7;
          eMosiValid = 1'b1;
`ifdef SPI_LSB_FIRST_EN
          eMosi = 1'(mTx >> idx);
`else
          eMosi = 1'(mTx >> (7 - idx));
`endif
        end
        eDone = (o == 17 * DIV);
      end
      eRx = mRx;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("gnt", 32'(gnt), 32'(eGnt));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("cs", 32'(CS), 32'(eCs));
      checkOutput("sclk", 32'(SCLK), 32'(eSclk));
      checkOutput("rx_data", 32'(rx_data), 32'(eRx));
      if (eMosiValid) checkOutput("mosi", 32'(MOSI), 32'(eMosi));
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [7:0] t0, input logic [7:0] t1);
    req     = r;
    tx_data = {t1, t0};
  endtask

  task automatic watchTransfer(output int doneAt, output int csLow, output int rises,
                               output logic [7:0] mosiBits, output logic [NUM_REQ-1:0] gntAtCs);
    logic prevSclk;
    bit   seenCs;
    doneAt = -1; csLow = 0; rises = 0; mosiBits = 8'h00; gntAtCs = '0;
    prevSclk = SCLK; seenCs = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      if (!CS) begin
        csLow++;
        if (!seenCs) begin
          seenCs  = 1'b1;
          gntAtCs = gnt;
        end
      end
      if (SCLK && !prevSclk) begin
        rises++;
        mosiBits = {mosiBits[6:0], MOSI};
      end
      prevSclk = SCLK;
      if (done) begin
        doneAt = i;
        break;
      end
    end
    checkOutput("done_seen", 32'(doneAt >= 0), 32'd1);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int                 doneAt, csLow, rises;
  logic [7:0]         bits;
  logic [NUM_REQ-1:0] gAtCs;

  initial begin
    $display("[TB] start");
    rst = 1'b1; req = '0; tx_data = '0; misoTied = 1'b0; misoLevel = 1'b0;
    req1 = '0; txData1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_cs", 32'(CS), 32'd1);
    checkOutput("rst_sclk", 32'(SCLK), 32'd0);
    checkOutput("rst_mosi", 32'(MOSI), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loopback of 0xA5; req and tx_data are disturbed mid-transfer.
    applyStimulus(2'b01, 8'hA5, 8'h00);
    fork
      watchTransfer(doneAt, csLow, rises, bits, gAtCs);
      begin
        repeat (10) @(negedge clk);
        applyStimulus(2'b00, 8'h00, 8'hFF);
      end
    join
    checkOutput("a5_gnt", 32'(gAtCs), 32'h1);
    checkOutput("a5_done_at", 32'(doneAt), 32'd69);
    checkOutput("a5_cs_low", 32'(csLow), 32'd68);
    checkOutput("a5_sclk_rises", 32'(rises), 32'd8);
    checkOutput("a5_mosi_bits", 32'(bits), 32'(sentOrder(8'hA5)));
    checkOutput("a5_rx", 32'(rx_data), 32'hA5);
    @(negedge clk);
    checkOutput("a5_done_width", 32'(done), 32'd0);

    // Both requesters held from reset: grants must alternate 0,1,0,1.
    pulseReset();
    applyStimulus(2'b11, 8'h5A, 8'h3C);
    for (int n = 0; n < 4; n++) begin
      watchTransfer(doneAt, csLow, rises, bits, gAtCs);
      checkOutput("rr_gnt", 32'(gAtCs), (n % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput("rr_mosi_bits", 32'(bits), 32'(sentOrder((n % 2 == 0) ? 8'h5A : 8'h3C)));
      checkOutput("rr_rx", 32'(rx_data), (n % 2 == 0) ? 32'h5A : 32'h3C);
    end
    applyStimulus(2'b00, 8'h00, 8'h00);

    // MISO tied high then low.
    misoTied = 1'b1; misoLevel = 1'b1;
    applyStimulus(2'b01, 8'h00, 8'h00);
    watchTransfer(doneAt, csLow, rises, bits, gAtCs);
    checkOutput("miso1_gnt", 32'(gAtCs), 32'h1);
    checkOutput("miso1_rx", 32'(rx_data), 32'hFF);
    @(negedge clk);
    checkOutput("miso1_done_width", 32'(done), 32'd0);
    misoLevel = 1'b0;
    applyStimulus(2'b01, 8'hFF, 8'h00);
    watchTransfer(doneAt, csLow, rises, bits, gAtCs);
    checkOutput("miso0_rx", 32'(rx_data), 32'h00);
    @(negedge clk);
    checkOutput("miso0_done_width", 32'(done), 32'd0);
    applyStimulus(2'b00, 8'h00, 8'h00);
    misoTied = 1'b0;

    // Abort during bit 3, then confirm the pointer was reset.
    repeat (DIV * 2) @(negedge clk);
    applyStimulus(2'b01, 8'h96, 8'h00);
    rises = 0;
    begin
      logic prevSclk;
      prevSclk = SCLK;
      for (int i = 0; i < TIMEOUT && rises < 4; i++) begin
        @(negedge clk);
        if (SCLK && !prevSclk) rises++;
        prevSclk = SCLK;
      end
    end
    checkOutput("abort_reached_bit3", 32'(rises), 32'd4);
    rst = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("abort_cs", 32'(CS), 32'd1);
    checkOutput("abort_sclk", 32'(SCLK), 32'd0);
    checkOutput("abort_gnt", 32'(gnt), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b11, 8'h5A, 8'hC3);
    watchTransfer(doneAt, csLow, rises, bits, gAtCs);
    checkOutput("post_abort_gnt", 32'(gAtCs), 32'h1);
    checkOutput("post_abort_rx", 32'(rx_data), 32'h5A);
    applyStimulus(2'b10, 8'h5A, 8'hC3);
    watchTransfer(doneAt, csLow, rises, bits, gAtCs);
    checkOutput("req1_gnt", 32'(gAtCs), 32'h2);
    checkOutput("req1_rx", 32'(rx_data), 32'hC3);
    applyStimulus(2'b00, 8'h00, 8'h00);

    // Fastest divider on the second instance.
    req1 = 2'b01; txData1 = 16'h0001;
    begin
      int   csLow1, doneAt1;
      bit   seen1;
      logic firstBit1;
      logic [NUM_REQ-1:0] firstGnt1;
      csLow1 = 0; doneAt1 = -1; seen1 = 1'b0; firstBit1 = 1'b0; firstGnt1 = '0;
      for (int i = 1; i <= TIMEOUT; i++) begin
        @(negedge clk);
        if (!cs1) begin
          csLow1++;
          if (!seen1) begin
            seen1 = 1'b1;
            firstBit1 = mosi1;
            firstGnt1 = gnt1;
          end
        end
        if (done1) begin
          doneAt1 = i;
          break;
        end
      end
      req1 = '0;
      checkOutput("div1_cs_low", 32'(csLow1), 32'd17);
      checkOutput("div1_done_at", 32'(doneAt1), 32'd18);
      checkOutput("div1_gnt", 32'(firstGnt1), 32'h1);
`ifdef SPI_LSB_FIRST_EN
      checkOutput("div1_first_bit", 32'(firstBit1), 32'd1);
`else
      checkOutput("div1_first_bit", 32'(firstBit1), 32'd0);
`endif
      checkOutput("div1_rx", 32'(rxData1), 32'h01);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
